// File: rtl/e_mdu_ctrl.sv
// E-stage multiply/divide unit controller: HI/LO registers, a multi-cycle busy window and MF/MT access.
// Macro MDU_DIV_EN enables div/divu; without it mdop 3/4 are no-ops and no divider is built.
module e_mdu_ctrl #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  mdop,
    input  logic [31:0] SrcA,
    input  logic [31:0] SrcB,
    input  logic        req,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] MDUout
);

    localparam int unsigned MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC + 1) : 1;

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MFHI  = 4'd7;
    localparam logic [3:0] OP_MFLO  = 4'd8;
`ifdef MDU_DIV_EN
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
`endif

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [63:0]        res, res_nxt;
    logic [31:0]        hi, hi_nxt;
    logic [31:0]        lo, lo_nxt;

    // Product/quotient are formed at issue and held in res until the busy window closes
    logic signed [63:0] mul_s;
    logic        [63:0] mul_u;

    assign mul_s = $signed({{32{SrcA[31]}}, SrcA}) * $signed({{32{SrcB[31]}}, SrcB});
    assign mul_u = {32'd0, SrcA} * {32'd0, SrcB};

`ifdef MDU_DIV_EN
    logic signed [31:0] sa, sb;
    logic        [31:0] q_s, r_s;
    logic        [63:0] div_s, div_u;

    assign sa  = $signed(SrcA);
    assign sb  = $signed(SrcB);
    assign q_s = 32'(sa / sb);
    assign r_s = 32'(sa % sb);

    // Zero divisor and the single signed overflow case get fixed results; {HI, LO} = {rem, quot}
    always_comb begin
        div_s = {r_s, q_s};
        div_u = {SrcA % SrcB, SrcA / SrcB};
        if (SrcB == 32'd0) begin
            div_s = {SrcA, 32'hFFFF_FFFF};
            div_u = {SrcA, 32'hFFFF_FFFF};
        end else if (SrcA == 32'h8000_0000 && SrcB == 32'hFFFF_FFFF) begin
            div_s = {32'd0, 32'h8000_0000};
        end
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            res   <= '0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            res   <= res_nxt;
            hi    <= hi_nxt;
            lo    <= lo_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        res_nxt   = res;
        hi_nxt    = hi;
        lo_nxt    = lo;
        unique case (state)
            IDLE: begin
                if (start && !req) begin
                    case (mdop)
                        OP_MULT: begin
                            res_nxt   = 64'(mul_s);
                            cnt_nxt   = CNT_W'(MULT_CYCLES - 1);
                            state_nxt = RUN;
                        end
                        OP_MULTU: begin
                            res_nxt   = mul_u;
                            cnt_nxt   = CNT_W'(MULT_CYCLES - 1);
                            state_nxt = RUN;
                        end
`ifdef MDU_DIV_EN
                        OP_DIV: begin
                            res_nxt   = div_s;
                            cnt_nxt   = CNT_W'(DIV_CYCLES - 1);
                            state_nxt = RUN;
                        end
                        OP_DIVU: begin
                            res_nxt   = div_u;
                            cnt_nxt   = CNT_W'(DIV_CYCLES - 1);
                            state_nxt = RUN;
                        end
`endif
                        OP_MTHI: hi_nxt = SrcA;
                        OP_MTLO: lo_nxt = SrcA;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                if (cnt == '0) begin
                    hi_nxt    = res[63:32];
                    lo_nxt    = res[31:0];
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy   = (state == RUN);
    assign HI     = hi;
    assign LO     = lo;
    assign MDUout = (mdop == OP_MFHI) ? hi : (mdop == OP_MFLO) ? lo : 32'd0;

endmodule

// File: tb/tb_e_mdu_ctrl.sv
// Bench for e_mdu_ctrl: arithmetic reference model checked every cycle plus literal expectations.
// Follows the MDU_DIV_EN macro so both builds can be exercised.
module tb_e_mdu_ctrl;

`ifdef MDU_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif
    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  mdop = 4'd0;
    logic [31:0] SrcA = 32'd0;
    logic [31:0] SrcB = 32'd0;
    logic        req = 1'b0;
    logic        busy;
    logic [31:0] HI, LO, MDUout;

    int n_chk = 0;
    int n_err = 0;

    e_mdu_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk(clk), .reset(reset), .start(start), .mdop(mdop), .SrcA(SrcA), .SrcB(SrcB),
        .req(req), .busy(busy), .HI(HI), .LO(LO), .MDUout(MDUout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: results computed with plain integer arithmetic, busy as a remaining-cycle count
    logic [31:0] m_hi = 32'd0, m_lo = 32'd0;
    logic [63:0] m_pend = 64'd0;
    int          m_left = 0;

    function automatic logic [63:0] ref_result(input logic [3:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        longint sa, sb, p, q, r;
        logic [63:0] ua, ub, up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            4'd1: begin p = sa * sb; return 64'(p); end
            4'd2: begin up = ua * ub; return up; end
            4'd3: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_hi = 32'd0; m_lo = 32'd0; m_pend = 64'd0; m_left = 0;
        end else if (m_left > 0) begin
            m_left = m_left - 1;
            if (m_left == 0) begin
                m_hi = m_pend[63:32];
                m_lo = m_pend[31:0];
            end
        end else if (start && !req) begin
            if (mdop == 4'd1 || mdop == 4'd2) begin
                m_pend = ref_result(mdop, SrcA, SrcB);
                m_left = MULT_N;
            end else if (DIV_EN && (mdop == 4'd3 || mdop == 4'd4)) begin
                m_pend = ref_result(mdop, SrcA, SrcB);
                m_left = DIV_N;
            end else if (mdop == 4'd5) begin
                m_hi = SrcA;
            end else if (mdop == 4'd6) begin
                m_lo = SrcA;
            end
        end
    end

    always @(negedge clk) begin
        chk("busy", {31'd0, busy}, {31'd0, m_left > 0});
        chk("HI", HI, m_hi);
        chk("LO", LO, m_lo);
        chk("MDUout", MDUout, (mdop == 4'd7) ? m_hi : (mdop == 4'd8) ? m_lo : 32'd0);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic flush);
        start = 1'b1; mdop = op; SrcA = a; SrcB = b; req = flush;
        step();
        start = 1'b0; mdop = 4'd0; req = 1'b0;
    endtask

    // Counts busy cycles still ahead; called right after the issuing edge
    task automatic wait_done(output int n);
        n = 0;
        while (busy && n < 100) begin
            n++;
            step();
        end
    endtask

    int n;

    initial begin
        step(); step();
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_hi", HI, 32'd0);
        chk("rst_lo", LO, 32'd0);

        // Start accepted on the first edge after release
        reset = 1'b1;
        issue(4'd1, 32'hFFFF_FFFE, 32'd3, 1'b0);
        wait_done(n);
        chk("mult_busy_cycles", n, 32'd5);
        chk("mult_hi", HI, 32'hFFFF_FFFF);
        chk("mult_lo", LO, 32'hFFFF_FFFA);

        issue(4'd5, 32'h1234_5678, 32'd0, 1'b0);
        chk("mthi_busy", {31'd0, busy}, 32'd0);
        chk("mthi", HI, 32'h1234_5678);
        issue(4'd6, 32'h0000_CAFE, 32'd0, 1'b0);
        chk("mtlo", LO, 32'h0000_CAFE);
        mdop = 4'd7; #1;
        chk("mfhi", MDUout, 32'h1234_5678);
        mdop = 4'd8; #1;
        chk("mflo", MDUout, 32'h0000_CAFE);
        mdop = 4'd12; #1;
        chk("mf_none", MDUout, 32'd0);
        issue(4'd12, 32'hDEAD_BEEF, 32'd1, 1'b0);
        chk("noop_busy", {31'd0, busy}, 32'd0);
        chk("noop_hi", HI, 32'h1234_5678);

        issue(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
        wait_done(n);
        if (DIV_EN) begin
            chk("div_busy_cycles", n, 32'd10);
            chk("div_lo", LO, 32'hFFFF_FFFD);
            chk("div_hi", HI, 32'hFFFF_FFFF);
            issue(4'd3, 32'h0000_0055, 32'd0, 1'b0);
            wait_done(n);
            chk("div0_lo", LO, 32'hFFFF_FFFF);
            chk("div0_hi", HI, 32'h0000_0055);
            issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
            wait_done(n);
            chk("divovf_lo", LO, 32'h8000_0000);
            chk("divovf_hi", HI, 32'd0);
            issue(4'd4, 32'd100, 32'd7, 1'b0);
            wait_done(n);
            chk("divu_lo", LO, 32'd14);
            chk("divu_hi", HI, 32'd2);
            issue(4'd4, 32'hFFFF_FFF0, 32'd0, 1'b0);
            wait_done(n);
            chk("divu0_lo", LO, 32'hFFFF_FFFF);
            chk("divu0_hi", HI, 32'hFFFF_FFF0);
        end else begin
            chk("nodiv_busy_cycles", n, 32'd0);
            chk("nodiv_hi", HI, 32'h1234_5678);
            chk("nodiv_lo", LO, 32'h0000_CAFE);
            issue(4'd4, 32'd100, 32'd7, 1'b0);
            chk("nodivu_busy", {31'd0, busy}, 32'd0);
            chk("nodivu_lo", LO, 32'h0000_CAFE);
        end

        // Flushed ops leave everything untouched
        mdop = 4'd7; #1;
        issue(4'd2, 32'h0000_0003, 32'h0000_0004, 1'b1);
        chk("flush_busy", {31'd0, busy}, 32'd0);
        chk("flush_hi", HI, m_hi);
        issue(4'd6, 32'h0BAD_0BAD, 32'd0, 1'b1);
        chk("flush_mtlo", LO, m_lo);

        // mthi during a multu is dropped; old LO visible through mflo while busy
        issue(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        start = 1'b1; mdop = 4'd5; SrcA = 32'h0000_1234;
        step();
        start = 1'b0; mdop = 4'd8; #1;
        chk("busy_mflo_old", MDUout, m_lo);
        wait_done(n);
        mdop = 4'd0;
        chk("multu_busy_cycles", n + 1, 32'd5);
        chk("multu_hi", HI, 32'hFFFF_FFFE);
        chk("multu_lo", LO, 32'h0000_0001);

        issue(4'd2, 32'hFFFF_FFFF, 32'd2, 1'b0);
        wait_done(n);
        chk("multu2_hi", HI, 32'h0000_0001);
        chk("multu2_lo", LO, 32'hFFFF_FFFE);
        issue(4'd1, 32'h8000_0000, 32'h8000_0000, 1'b0);
        wait_done(n);
        chk("mult_min_hi", HI, 32'h4000_0000);
        chk("mult_min_lo", LO, 32'h0000_0000);

        // Reset on busy cycle 3 aborts the op at once
        issue(DIV_EN ? 4'd3 : 4'd1, 32'd1000, 32'd3, 1'b0);
        step(); step();
        chk("pre_rst_busy", {31'd0, busy}, 32'd1);
        reset = 1'b0; #1;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_hi", HI, 32'd0);
        chk("midrst_lo", LO, 32'd0);
        step(); step();
        reset = 1'b1;
        issue(4'd1, 32'd7, 32'hFFFF_FFFD, 1'b0);
        wait_done(n);
        chk("postrst_busy_cycles", n, 32'd5);
        chk("postrst_hi", HI, 32'hFFFF_FFFF);
        chk("postrst_lo", LO, 32'hFFFF_FFEB);

        step(); step();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/e_mdu_ctrl.md
E_MDU_CTRL -- requirements
Module: e_mdu_ctrl

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5, busy cycles for mult/multu.
REQ-002 SHALL have parameter DIV_CYCLES, default 10, busy cycles for div/divu.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  E-stage instruction is an MDU op this cycle.
REQ-006 SHALL have port mdop  input  4  op code: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 mfhi, 8 mflo; 9-15 none.
REQ-007 SHALL have port SrcA  input  32  operand A; also the mthi/mtlo write data.
REQ-008 SHALL have port SrcB  input  32  operand B, the divisor for div/divu.
REQ-009 SHALL have port req  input  1  exception/interrupt flush; cancels the E-stage op this cycle.
REQ-010 SHALL have port busy  output  1  multi-cycle op in flight.
REQ-011 SHALL have port HI  output  32  HI register.
REQ-012 SHALL have port LO  output  32  LO register.
REQ-013 SHALL have port MDUout  output  32  combinational read data: HI for mfhi, LO for mflo, else 0.

Function
REQ-014 SHALL implement FSM states IDLE and RUN plus a down-counter cnt sized to hold max(MULT_CYCLES, DIV_CYCLES).
REQ-015 SHALL, in IDLE with start=1, req=0 and mdop in 1..4, latch the 64-bit result, load cnt=N-1 (N per op) and enter RUN; busy SHALL read 1 from the next cycle.
REQ-016 SHALL keep busy=1 for exactly N cycles; in RUN cnt decrements each cycle; at cnt=0 the next edge writes HI/LO and returns to IDLE (busy=0).
REQ-017 SHALL compute mult as signed 32x32->64 and multu as unsigned; HI=upper 32 bits, LO=lower 32 bits.
REQ-018 SHALL compute div/divu as LO=quotient, HI=remainder; signed quotient truncates toward zero and the remainder takes the dividend's sign.
REQ-019 SHALL, for divisor 0, write LO=32'hFFFF_FFFF and HI=SrcA, signed or unsigned.
REQ-020 SHALL, for signed 32'h8000_0000 / 32'hFFFF_FFFF, write LO=32'h8000_0000 and HI=0.
REQ-021 SHALL, for mthi/mtlo with start=1, req=0 and busy=0, write SrcA into HI/LO at the next edge with no busy cycles.
REQ-022 SHALL ignore start with req=1 (no state, HI or LO change).
REQ-023 SHALL ignore start while busy=1, whatever mdop, because stalling is the hazard unit's job; an in-flight op SHALL complete regardless of req.
REQ-024 SHALL drive MDUout from the current HI/LO register values; during RUN these are the old values.
REQ-025 SHALL take mdop 0 and 9-15 as no-ops.

Reset
REQ-026 SHALL, on reset=0 and asynchronously, force state=IDLE, cnt=0, busy=0, HI=0, LO=0 and the latched result to 0.
REQ-027 SHALL, when reset is asserted during RUN, abort the op; HI/LO stay 0 and busy drops immediately.
REQ-028 SHALL accept a start from the first rising edge after reset deasserts.

Configuration
REQ-029 SHALL, with macro MDU_DIV_EN defined, implement div/divu as specified.
REQ-030 SHALL, without MDU_DIV_EN, treat mdop 3/4 as no-ops: no busy, HI/LO unchanged, no divider logic synthesized.

Verification
REQ-031 SHALL cover mult: SrcA=32'hFFFF_FFFE, SrcB=3, start one cycle -> busy high exactly 5 cycles, then HI=32'hFFFF_FFFF and LO=32'hFFFF_FFFA.
REQ-032 SHALL cover div: SrcA=-7, SrcB=2 -> busy 10 cycles, then LO=32'hFFFF_FFFD (-3) and HI=32'hFFFF_FFFF (-1); with SrcB=0 -> LO=32'hFFFF_FFFF and HI=SrcA.
REQ-033 SHALL cover flush: start=1, req=1, mdop=multu -> busy stays 0 and HI/LO unchanged; mtlo with req=1 -> LO unchanged.
REQ-034 SHALL cover start while busy: during a multu, issue mthi SrcA=32'h1234 -> ignored; after completion HI equals the product's upper half.
REQ-035 SHALL cover mid-op reset: reset low on busy cycle 3 of a div -> busy=0, HI=LO=0 immediately; a mult issued after release completes normally.
REQ-036 SHALL cover a build without MDU_DIV_EN: div start -> busy stays 0 and HI/LO unchanged.
